// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two requesters onto the single-port valid/ready memory.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module mem_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  valid0,
  input  logic                  valid1,
  input  logic                  wr_rd0,
  input  logic                  wr_rd1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]      wdata0,
  input  logic [WIDTH-1:0]      wdata1,
  output logic                  ready0,
  output logic                  ready1,
  output logic [WIDTH-1:0]      rdata0,
  output logic [WIDTH-1:0]      rdata1,
  output logic                  busy,
  output logic                  m_valid,
  output logic                  m_wr_rd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wdata,
  input  logic [WIDTH-1:0]      m_rdata,
  input  logic                  m_ready
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic grant, capture, win, gnt;
`ifdef MEM_ARB_RR_EN
  logic last;
  always_ff @(posedge clk or posedge res)
    if (res) last <= 1'b1;
    else if (grant) last <= win;
  assign win = (valid0 && valid1) ? ~last : valid1;
`else
  assign win = ~valid0;
`endif
  // DONE never grants, so a valid held through its ready pulse is not re-issued
  always_comb begin
    grant = state == IDLE && (valid0 || valid1);
    capture = state == WAIT && m_ready && !m_wr_rd;
    state_nx = grant ? ISSUE :
               state == ISSUE ? WAIT :
               state == WAIT && m_ready ? DONE :
               state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or posedge res)
    if (res) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge res)
    if (res) begin
      gnt <= 1'b0;
      m_wr_rd <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
    end else if (grant) begin
      gnt <= win;
      m_wr_rd <= win ? wr_rd1 : wr_rd0;
      m_addr <= win ? addr1 : addr0;
      m_wdata <= win ? wdata1 : wdata0;
    end
  always_ff @(posedge clk or posedge res)
    if (res) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (capture) begin
      if (gnt) rdata1 <= m_rdata;
      else rdata0 <= m_rdata;
    end
  assign busy = state != IDLE;
  assign m_valid = state == ISSUE;
  assign ready0 = state == DONE && !gnt;
  assign ready1 = state == DONE && gnt;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port synchronous `memory` block (valid/ready, one-cycle registered response) between two independent masters. It serialises requests, drives the memory's command port for exactly one cycle per transaction, captures the response and returns a one-cycle `ready` pulse plus read data to the winning requester. It sits directly in front of `memory`, with both blocks sharing `clk` and `res`.

## Interface
- `WIDTH`, 8, data width; must match `memory`.
- `DEPTH`, 32, memory depth; must match `memory`.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `res`  in  1  reset. **One clock; reset is asynchronous and active-high.**
- `valid0`, `valid1`  in  1  request from requester 0/1; held until its `ready` pulse.
- `wr_rd0`, `wr_rd1`  in  1  1 = write, 0 = read; stable while `valid` is high.
- `addr0`, `addr1`  in  ADDR_WIDTH  request address; stable while `valid` is high.
- `wdata0`, `wdata1`  in  WIDTH  write data; stable while `valid` is high.
- `ready0`, `ready1`  out  1  one-cycle completion pulse to requester 0/1.
- `rdata0`, `rdata1`  out  WIDTH  read data returned to requester 0/1.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `m_valid`  out  1  command strobe to the memory.
- `m_wr_rd`  out  1  command direction to the memory.
- `m_addr`  out  ADDR_WIDTH  command address.
- `m_wdata`  out  WIDTH  command write data.
- `m_rdata`  in  WIDTH  memory read data.
- `m_ready`  in  1  memory response strobe.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- **IDLE**
  - If neither `valid` is high, stay in IDLE.
  - Otherwise select a winner and latch its `wr_rd`/`addr`/`wdata` into command registers and its index into `gnt`, then go to ISSUE.
- **ISSUE**
  - `m_valid`=1 for exactly this cycle.
  - `m_wr_rd`/`m_addr`/`m_wdata` come from the command registers.
  - Go to WAIT unconditionally.
- **WAIT**
  - `m_valid`=0.
  - When `m_ready`=1: if the command is a read, latch `m_rdata` into `rdata[gnt]`; then go to DONE.
  - While `m_ready`=0, stay in WAIT indefinitely. There is no timeout.
- **DONE**
  - `ready[gnt]`=1 for this cycle only.
  - Requests are ignored in this cycle, so a `valid` still high while `ready` is asserted is never double-counted.
  - Go to IDLE.
- Arbitration with both `valid` high in IDLE: round-robin; grant the requester that was not granted last.
- Last-granted pointer: resets to 1, so requester 0 wins the first contention. It updates on every grant.
- With a single `valid` high, that requester wins regardless of the pointer.
- `m_wr_rd`, `m_addr`, `m_wdata` hold the last command outside ISSUE.
- `rdata0`/`rdata1` hold their last read value. Writes never change them.
- Asynchronous `res` mid-transaction aborts it:
  - FSM returns to IDLE and `m_valid` drops immediately.
  - No `ready` is issued for the aborted request; the requester must re-present it after reset.

## Timing
- Reset values: `ready0`=`ready1`=0, `rdata0`=`rdata1`=0, `busy`=0, `m_valid`=0, `m_wr_rd`=0, `m_addr`=0, `m_wdata`=0, pointer=1.
- Latency: `valid` first sampled high at edge E0 in IDLE gives ISSUE in cycle E0+1, WAIT (memory `m_ready`=1) in E0+2, and DONE with `ready`=1 and `rdata` valid in E0+3.
- Throughput: one transaction per 4 cycles. Back-to-back requests from alternating requesters complete every 4 cycles.
- A requester dropping `valid` before its `ready` is a protocol violation; the latched command still completes.
- All outputs are registered or decoded from state registers only. There are no combinational paths from inputs to outputs.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration as described above.
- `MEM_ARB_RR_EN` undefined: fixed priority. Requester 0 always wins contention; the pointer logic is removed. Requester 1 can starve while requester 0 keeps `valid` high.

## Test plan
- Reset, then single write from requester 0 (addr 5, wdata 8'hA5) followed by a read of addr 5 → `m_valid` pulses once per request; `ready0` is high 3 cycles after each `valid0`; `rdata0`=8'hA5; `ready1` stays 0.
- Both requesters present reads simultaneously and continuously (RR enabled) → grants alternate 0,1,0,1; `ready0` and `ready1` pulses are spaced 4 cycles apart.
- Same stimulus with `MEM_ARB_RR_EN` undefined → only requester 0 is granted while `valid0` stays high.
- Requester 1 writes 8'h3C to addr 31 while requester 0 reads addr 31 in the following IDLE → `rdata0`=8'h3C; `rdata1` is unchanged.
- Assert `res` during WAIT → `busy`/`m_valid`/`ready*` go 0 asynchronously; no `ready` is issued; the first post-reset request completes normally.
- Hold `valid0` high through its `ready0` pulse and drop it one cycle later → exactly one memory command is issued.
